// File: rtl/smvm_pkg.sv
// smvm_pkg: state encodings, datapath widths and nonzero entry type shared by the SMVM stream transmitter
package smvm_pkg;
   localparam int VAL_W = 8;
   localparam int COL_W = 8;
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] HDR  = 3'd1;
   localparam logic [2:0] VEC  = 3'd2;
   localparam logic [2:0] MAT  = 3'd3;
   localparam logic [2:0] TERM = 3'd4;
   typedef struct packed {
      logic [VAL_W-1:0] val;
      logic [COL_W-1:0] col;
      logic             ipv;
   } nz_t;
endpackage

// File: rtl/smvm_tx_store.sv
// smvm_tx_store: vector and nonzero storage, one write port and one combinational read port each
module smvm_tx_store
   import smvm_pkg::*;
#(
   parameter int MAX_COLS = 128,
   parameter int MAX_NNZ  = 256,
   parameter int NW       = 9,
   localparam int VA      = $clog2(MAX_COLS),
   localparam int NA      = $clog2(MAX_NNZ)
) (
   input  logic             clk,
   input  logic             we,
   input  logic             sel,
   input  logic [NW-1:0]    waddr,
   input  logic [VAL_W-1:0] wval,
   input  logic [COL_W-1:0] wcol,
   input  logic             wipv,
   input  logic [VA-1:0]    vec_raddr,
   input  logic [NA-1:0]    nz_raddr,
   output logic [VAL_W-1:0] vec_rdata,
   output nz_t              nz_rdata
);
   logic [VAL_W-1:0] vec_mem [MAX_COLS];
   nz_t              nz_mem  [MAX_NNZ];
   // out-of-range addresses are silently dropped
   always_ff @(posedge clk) begin
      if (we && !sel && 32'(waddr) < MAX_COLS) vec_mem[waddr[VA-1:0]] <= wval;
      if (we && sel && 32'(waddr) < MAX_NNZ) nz_mem[waddr[NA-1:0]] <= '{wval, wcol, wipv};
   end
   assign vec_rdata = vec_mem[vec_raddr];
   assign nz_rdata  = nz_mem[nz_raddr];
endmodule

// File: rtl/smvm_stream_tx.sv
// smvm_stream_tx: serializes header, vector, CSR nonzeros and a zero terminator onto the SMVM val/col/ipv wires
// Define SMVM_TX_COL_CHECK_EN to abort the job on any nonzero whose column is >= cols.
module smvm_stream_tx
   import smvm_pkg::*;
#(
   parameter int K        = 4,
   parameter int MAX_COLS = 128,
   parameter int MAX_NNZ  = 256,
   parameter int NW       = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic             cfg_sel,
   input  logic [NW-1:0]    cfg_addr,
   input  logic [VAL_W-1:0] cfg_val,
   input  logic [COL_W-1:0] cfg_col,
   input  logic             cfg_ipv,
   input  logic             start,
   input  logic [VAL_W-1:0] rows,
   input  logic [COL_W-1:0] cols,
   input  logic [NW-1:0]    nnz,
   output logic [VAL_W-1:0] val_out,
   output logic [COL_W-1:0] col_out,
   output logic             ipv_out,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             k_aligned
);
   localparam int VA = $clog2(MAX_COLS);
   localparam int NA = $clog2(MAX_NNZ);
   logic [2:0]       state;
   logic [VAL_W-1:0] rows_q;
   logic [COL_W-1:0] cols_q;
   logic [NW-1:0]    nnz_q, idx, row_cnt, nz_addr;
   logic             err_latch, nz_bad, nz_emit, mat_go, start_bad;
   logic [VAL_W-1:0] vec_rd;
   nz_t              nz_rd;

   smvm_tx_store #(.MAX_COLS(MAX_COLS), .MAX_NNZ(MAX_NNZ), .NW(NW)) u_store (
      .clk(clk),
      .we(cfg_we && state == IDLE),
      .sel(cfg_sel),
      .waddr(cfg_addr),
      .wval(cfg_val),
      .wcol(cfg_col),
      .wipv(cfg_ipv),
      .vec_raddr(idx[VA-1:0]),
      .nz_raddr(nz_addr[NA-1:0]),
      .vec_rdata(vec_rd),
      .nz_rdata(nz_rd)
   );

   // state tracks the beat currently on the outputs, so the first nonzero is fetched from VEC
   always_comb begin
      nz_addr = state == MAT ? idx : '0;
`ifdef SMVM_TX_COL_CHECK_EN
      nz_bad = nz_rd.val == '0 || nz_rd.col >= cols_q;
`else
      nz_bad = nz_rd.val == '0;
`endif
      nz_emit = !nz_bad && (nz_rd.ipv || nz_addr == nnz_q - NW'(1));
      mat_go = (state == VEC && idx == NW'(cols_q)) || (state == MAT && idx != nnz_q);
      start_bad = rows == '0 || cols == '0 || 32'(cols) > MAX_COLS || nnz == '0 || 32'(nnz) > MAX_NNZ;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rows_q    <= '0;
         cols_q    <= '0;
         nnz_q     <= '0;
         idx       <= '0;
         row_cnt   <= '0;
         err_latch <= 1'b0;
         val_out   <= '0;
         col_out   <= '0;
         ipv_out   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         k_aligned <= 1'b0;
      end else begin
         done      <= 1'b0;
         err       <= 1'b0;
         k_aligned <= 1'b0;
         if (mat_go) begin
            state     <= MAT;
            val_out   <= nz_bad ? '0 : nz_rd.val;
            col_out   <= nz_bad ? '0 : nz_rd.col;
            ipv_out   <= nz_emit;
            row_cnt   <= row_cnt + NW'(nz_emit);
            err_latch <= err_latch || nz_bad;
            idx       <= nz_bad ? nnz_q : nz_addr + NW'(1);
         end else if (state == IDLE) begin
            if (start && start_bad) begin
               err <= 1'b1;
            end else if (start) begin
               state     <= HDR;
               rows_q    <= rows;
               cols_q    <= cols;
               nnz_q     <= nnz;
               idx       <= '0;
               row_cnt   <= '0;
               err_latch <= 1'b0;
               busy      <= 1'b1;
               val_out   <= rows;
               col_out   <= cols;
               ipv_out   <= 1'b0;
            end
         end else if (state == HDR || state == VEC) begin
            state   <= VEC;
            val_out <= vec_rd;
            col_out <= '0;
            ipv_out <= 1'b0;
            idx     <= idx + NW'(1);
         end else if (state == MAT) begin
            state     <= TERM;
            val_out   <= '0;
            col_out   <= '0;
            ipv_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            err       <= err_latch || row_cnt != NW'(rows_q);
            k_aligned <= (32'(nnz_q) % K) == 0;
         end else begin
            state <= IDLE;
         end
      end
   end
endmodule
